// File: rtl/uart_baud_gen.sv
// uart_baud_gen: fractional baud-rate generator producing the oversample tick
// and a bit tick every OSR oversample ticks. Divisor writes are double-buffered
// and only reach the active pair on a tick boundary or while disabled.
// Optional feature macro: UART_BAUD_FRAC_EN (fractional accumulator present).
module uart_baud_gen #(
    parameter int unsigned DIV_W    = 16,
    parameter int unsigned FRAC_W   = 4,
    parameter int unsigned OSR      = 16,
    parameter int unsigned DEF_DIV  = 27,
    parameter int unsigned DEF_FRAC = 2
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              baud_en_i,
    input  logic              div_wen_i,
    input  logic [DIV_W-1:0]  div_int_i,
    input  logic [FRAC_W-1:0] div_frac_i,
    output logic              osr_tick_o,
    output logic              baud_tick_o,
    output logic              div_pending_o,
    output logic              div_clamp_o
);

    localparam int unsigned CNT_W = DIV_W + 1;
    localparam int unsigned OSR_W = (OSR > 1) ? $clog2(OSR) : 1;
    localparam int unsigned SUM_W = FRAC_W + 1;

    logic [DIV_W-1:0] r_act_int;
    logic [DIV_W-1:0] r_sh_int;
    logic [DIV_W-1:0] w_act_int_nxt;
    logic [DIV_W-1:0] w_d;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_period;
    logic [OSR_W-1:0] r_osr_cnt;
    logic             r_osr_tick;
    logic             r_baud_tick;
    logic             r_pending;
    logic             r_clamp;
    logic             w_carry;
    logic             w_wrap;
    logic             w_xfer;

`ifdef UART_BAUD_FRAC_EN
    logic [FRAC_W-1:0] r_act_frac;
    logic [FRAC_W-1:0] r_sh_frac;
    logic [FRAC_W-1:0] r_acc;
    logic [FRAC_W-1:0] w_act_frac_nxt;
    logic              r_carry;
    logic [SUM_W-1:0]  w_sum;

    assign w_carry = r_carry;
    assign w_sum   = SUM_W'(r_acc) + SUM_W'(r_act_frac);
`else
    // Fraction path absent: period is the bare integer divisor.
    logic w_unused_frac;
    assign w_unused_frac = ^{div_frac_i, FRAC_W'(DEF_FRAC)};
    assign w_carry       = 1'b0;
`endif

    // Effective divisor is clamped to 2 so a tick can never repeat back-to-back.
    assign w_d      = (r_act_int < DIV_W'(2)) ? DIV_W'(2) : r_act_int;
    assign w_period = CNT_W'(w_d) + CNT_W'(w_carry);
    assign w_wrap   = baud_en_i && (r_cnt == (w_period - CNT_W'(1)));
    assign w_xfer   = w_wrap || !baud_en_i;

    // Next active integer divisor: a coincident write bypasses the shadow.
    always_comb begin
        w_act_int_nxt = r_act_int;
        if (w_xfer) begin
            w_act_int_nxt = div_wen_i ? div_int_i : r_sh_int;
        end
    end

    // Period counter, oversample counter and registered tick outputs.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_cnt       <= '0;
            r_osr_cnt   <= '0;
            r_osr_tick  <= 1'b0;
            r_baud_tick <= 1'b0;
        end else if (!baud_en_i) begin
            r_cnt       <= '0;
            r_osr_cnt   <= '0;
            r_osr_tick  <= 1'b0;
            r_baud_tick <= 1'b0;
        end else if (w_wrap) begin
            r_cnt       <= '0;
            r_osr_tick  <= 1'b1;
            r_baud_tick <= (r_osr_cnt == OSR_W'(OSR - 1));
            r_osr_cnt   <= (r_osr_cnt == OSR_W'(OSR - 1)) ? '0 : r_osr_cnt + OSR_W'(1);
        end else begin
            r_cnt       <= r_cnt + CNT_W'(1);
            r_osr_tick  <= 1'b0;
            r_baud_tick <= 1'b0;
        end
    end

    // Integer divisor shadow/active pair, pending flag and clamp flag.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_act_int <= DIV_W'(DEF_DIV);
            r_sh_int  <= DIV_W'(DEF_DIV);
            r_pending <= 1'b0;
            r_clamp   <= 1'b0;
        end else begin
            r_act_int <= w_act_int_nxt;
            r_clamp   <= (w_act_int_nxt < DIV_W'(2));
            if (div_wen_i) begin
                r_sh_int <= div_int_i;
            end
            if (div_wen_i && !w_xfer) begin
                r_pending <= 1'b1;
            end else if (w_xfer) begin
                r_pending <= 1'b0;
            end
        end
    end

`ifdef UART_BAUD_FRAC_EN
    // Next active fractional divisor, same transfer rule as the integer part.
    always_comb begin
        w_act_frac_nxt = r_act_frac;
        if (w_xfer) begin
            w_act_frac_nxt = div_wen_i ? div_frac_i : r_sh_frac;
        end
    end

    // Fractional divisor shadow/active pair.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_act_frac <= FRAC_W'(DEF_FRAC);
            r_sh_frac  <= FRAC_W'(DEF_FRAC);
        end else begin
            r_act_frac <= w_act_frac_nxt;
            if (div_wen_i) begin
                r_sh_frac <= div_frac_i;
            end
        end
    end

    // Fraction accumulator; its carry stretches the following period by one.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_acc   <= '0;
            r_carry <= 1'b0;
        end else if (!baud_en_i) begin
            r_acc   <= '0;
            r_carry <= 1'b0;
        end else if (w_wrap) begin
            {r_carry, r_acc} <= w_sum;
        end
    end
`endif

    assign osr_tick_o    = r_osr_tick;
    assign baud_tick_o   = r_baud_tick;
    assign div_pending_o = r_pending;
    assign div_clamp_o   = r_clamp;

endmodule

// File: tb/tb_uart_baud_gen.sv
// tb_uart_baud_gen: directed bench for uart_baud_gen with hand-computed periods.
`timescale 1ns/1ps
module tb_uart_baud_gen;

`ifdef UART_BAUD_FRAC_EN
    localparam bit FRAC = 1'b1;
`else
    localparam bit FRAC = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        baud_en_i;
    logic        div_wen_i;
    logic [15:0] div_int_i;
    logic [3:0]  div_frac_i;
    logic        osr_tick_o;
    logic        baud_tick_o;
    logic        div_pending_o;
    logic        div_clamp_o;

    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   tk [0:40];
    logic bk [0:40];
    logic g_baud;
    int   c0, t1, t2, t3, t4, t5, t6, cnt_tk, adj;
    logic prev;

    uart_baud_gen dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .baud_en_i     (baud_en_i),
        .div_wen_i     (div_wen_i),
        .div_int_i     (div_int_i),
        .div_frac_i    (div_frac_i),
        .osr_tick_o    (osr_tick_o),
        .baud_tick_o   (baud_tick_o),
        .div_pending_o (div_pending_o),
        .div_clamp_o   (div_clamp_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // Advance to the next negedge with osr_tick_o high; returns its cycle stamp.
    task automatic wait_tick(input string tag, input int budget, output int t);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_i);
            if (osr_tick_o) begin
                t      = cyc;
                g_baud = baud_tick_o;
                break;
            end
        end
        if (t < 0) begin
            n_chk++;
            n_err++;
            $display("FAIL %s_timeout got none exp tick", tag);
        end
    endtask

    task automatic run_ticks(input string tag, input int n);
        int t;
        for (int k = 1; k <= n; k++) begin
            wait_tick(tag, 100, t);
            tk[k] = t;
            bk[k] = g_baud;
        end
    endtask

    // One-cycle divisor write; called at a negedge, returns at the next negedge.
    task automatic wr_div(input int di, input int df);
        div_wen_i  = 1'b1;
        div_int_i  = 16'(di);
        div_frac_i = 4'(df);
        @(negedge clk_i);
        div_wen_i  = 1'b0;
    endtask

    initial begin
        reset_i    = 1'b0;
        baud_en_i  = 1'b0;
        div_wen_i  = 1'b0;
        div_int_i  = '0;
        div_frac_i = '0;
        repeat (3) @(negedge clk_i);

        // Reset defaults
        chk("rst_osr",   int'(osr_tick_o), 0);
        chk("rst_baud",  int'(baud_tick_o), 0);
        chk("rst_pend",  int'(div_pending_o), 0);
        chk("rst_clamp", int'(div_clamp_o), 0);

        reset_i   = 1'b1;
        baud_en_i = 1'b1;
        c0 = cyc;
        run_ticks("t1", 17);
        chk("t1_lat",    tk[1] - c0, 27);
        chk("t1_b1",     int'(bk[1]), 0);
        chk("t1_b15",    int'(bk[15]), 0);
        chk("t1_b16",    int'(bk[16]), 1);
        chk("t1_b17",    int'(bk[17]), 0);
        chk("t1_sum16",  tk[17] - tk[1], FRAC ? 434 : 432);

        // Integer period 4
        baud_en_i = 1'b0;
        @(negedge clk_i);
        wr_div(4, 0);
        chk("t2_pend", int'(div_pending_o), 0);
        baud_en_i = 1'b1;
        c0 = cyc;
        run_ticks("t2", 32);
        chk("t2_lat",   tk[1] - c0, 4);
        chk("t2_per",   tk[2] - tk[1], 4);
        chk("t2_b15",   int'(bk[15]), 0);
        chk("t2_b16",   int'(bk[16]), 1);
        chk("t2_b32",   int'(bk[32]), 1);
        chk("t2_bgap",  tk[32] - tk[16], 64);

        // Half fraction 4 + 8/16
        baud_en_i = 1'b0;
        @(negedge clk_i);
        wr_div(4, 8);
        baud_en_i = 1'b1;
        c0 = cyc;
        run_ticks("t3", 17);
        chk("t3_p1",    tk[1] - c0, 4);
        chk("t3_p2",    tk[2] - tk[1], 4);
        chk("t3_p3",    tk[3] - tk[2], FRAC ? 5 : 4);
        chk("t3_p4",    tk[4] - tk[3], 4);
        chk("t3_p5",    tk[5] - tk[4], FRAC ? 5 : 4);
        chk("t3_sum16", tk[17] - tk[1], FRAC ? 72 : 64);

        // Shadowed update 10 -> 6, then a write coincident with the wrap edge
        baud_en_i = 1'b0;
        @(negedge clk_i);
        wr_div(10, 0);
        baud_en_i = 1'b1;
        c0 = cyc;
        wait_tick("t4a", 100, t1);
        chk("t4_lat", t1 - c0, 10);
        repeat (2) @(negedge clk_i);
        wr_div(6, 0);
        chk("t4_pend1", int'(div_pending_o), 1);
        chk("t4_clamp", int'(div_clamp_o), 0);
        wait_tick("t4b", 100, t2);
        chk("t4_old",   t2 - t1, 10);
        chk("t4_pend0", int'(div_pending_o), 0);
        wait_tick("t4c", 100, t3);
        chk("t4_new",   t3 - t2, 6);
        repeat (5) @(negedge clk_i);
        wr_div(8, 0);
        chk("t4_coin_pend", int'(div_pending_o), 0);
        chk("t4_coin_tick", int'(osr_tick_o), 1);
        t4 = cyc;
        chk("t4_coin_gap", t4 - t3, 6);
        wait_tick("t4d", 100, t5);
        chk("t4_coin_p1", t5 - t4, 8);
        wait_tick("t4e", 100, t6);
        chk("t4_coin_p2", t6 - t5, 8);

        // Clamp: divisor 0 behaves as 2
        baud_en_i = 1'b0;
        @(negedge clk_i);
        wr_div(0, 0);
        chk("t5_clamp", int'(div_clamp_o), 1);
        baud_en_i = 1'b1;
        c0 = cyc;
        run_ticks("t5", 6);
        chk("t5_lat",  tk[1] - c0, 2);
        chk("t5_per",  tk[2] - tk[1], 2);
        chk("t5_sum5", tk[6] - tk[1], 10);
        adj  = 0;
        prev = osr_tick_o;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (prev && osr_tick_o) adj++;
            prev = osr_tick_o;
        end
        chk("t5_adj", adj, 0);
        // Async reset during a tick cycle clears outputs at once
        wait_tick("t5r", 100, t1);
        reset_i = 1'b0;
        #1;
        chk("t5_rst_osr",   int'(osr_tick_o), 0);
        chk("t5_rst_clamp", int'(div_clamp_o), 0);
        baud_en_i = 1'b0;
        @(negedge clk_i);
        reset_i = 1'b1;
        @(negedge clk_i);

        // Disable mid-period at cnt 5 of 10
        wr_div(10, 0);
        baud_en_i = 1'b1;
        c0 = cyc;
        wait_tick("t6a", 100, t1);
        chk("t6_lat", t1 - c0, 10);
        repeat (5) @(negedge clk_i);
        baud_en_i = 1'b0;
        cnt_tk = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk_i);
            if (osr_tick_o) cnt_tk++;
        end
        chk("t6_dis_none", cnt_tk, 0);
        baud_en_i = 1'b1;
        c0 = cyc;
        wait_tick("t6b", 100, t2);
        chk("t6_reen_lat", t2 - c0, 10);

        // Reset mid-period with a pending write
        repeat (2) @(negedge clk_i);
        wr_div(5, 0);
        chk("t6_pend1", int'(div_pending_o), 1);
        #2;
        reset_i = 1'b0;
        #1;
        chk("t6_rst_pend", int'(div_pending_o), 0);
        chk("t6_rst_osr",  int'(osr_tick_o), 0);
        cnt_tk = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk_i);
            if (osr_tick_o) cnt_tk++;
        end
        chk("t6_rst_none", cnt_tk, 0);
        reset_i = 1'b1;
        c0 = cyc;
        wait_tick("t6c", 100, t3);
        chk("t6_def_lat", t3 - c0, 27);
        wait_tick("t6d", 100, t4);
        chk("t6_def_per", t4 - t3, 27);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/uart_baud_gen.md
# uart_baud_gen

Fractional baud-rate generator that produces the oversample tick (`osr_tick_o`) consumed by the TX and RX paths, plus a bit-rate tick every `OSR` oversample ticks. It sits between the register interface and the TX/RX paths. Divisor writes from the register interface are double-buffered: they take effect only on an oversample-tick boundary or while the generator is disabled, so a rate change never produces a runt tick period.

## Interface
Parameters:
- `DIV_W`, 16, integer-divisor width
- `FRAC_W`, 4, fractional-divisor width (units of 1/2^FRAC_W)
- `OSR`, 16, oversample ticks per bit tick
- `DEF_DIV`, 27, reset value of the active integer divisor
- `DEF_FRAC`, 2, reset value of the active fractional divisor

Ports:
- `clk_i` in 1: clock.
- `reset_i` in 1: reset. Asynchronous assertion, active-low. Synchronous deassertion is guaranteed externally.
- `baud_en_i` in 1: generator enable.
- `div_wen_i` in 1: divisor write strobe, one cycle.
- `div_int_i` in DIV_W: integer divisor write data.
- `div_frac_i` in FRAC_W: fractional divisor write data.
- `osr_tick_o` out 1: oversample tick, one-cycle pulse.
- `baud_tick_o` out 1: bit tick, one-cycle pulse, coincident with every OSR-th `osr_tick_o`.
- `div_pending_o` out 1: a written divisor is waiting in the shadow register.
- `div_clamp_o` out 1: the active integer divisor is below 2 and is being clamped.

## Operation
State:
- `cnt` (DIV_W+1 bits)
- `acc` (FRAC_W bits)
- `osr_cnt` (clog2(OSR) bits)
- `carry` (1 bit)
- shadow divisor pair and active divisor pair

Period and ticks:
- Effective integer divisor: `D = max(div_int_active, 2)`.
- Period: `P = D + carry`.
- `div_clamp_o = (div_int_active < 2)`.
- While enabled, `cnt` counts up from 0. The edge at which `cnt == P-1` is the **wrap edge**. At the wrap edge:
  - `cnt` is set to 0.
  - `osr_tick_o` is registered high for the following cycle.
  - `{carry, acc}` is set to `acc + frac_active` (FRAC_W+1-bit sum). This `carry` applies to the next period.
  - `osr_cnt` increments modulo OSR. `baud_tick_o` is registered high alongside `osr_tick_o` when `osr_cnt` wraps from OSR-1 to 0.
- Average period is `D + frac/2^FRAC_W`. Over any 2^FRAC_W consecutive periods, the sum is exactly `2^FRAC_W*D + frac`.

Divisor update:
- `div_wen_i` loads the shadow pair and sets `div_pending_o`.
- The shadow transfers to the active pair, and `div_pending_o` clears, at a wrap edge or at any edge with `baud_en_i` low.
- If `div_wen_i` coincides with a transfer edge, the written values bypass the shadow and go straight to active. In that case `div_pending_o` stays 0.
- A new divisor governs the period that starts after the transfer. `acc` and `carry` are not cleared by a transfer.

Disable:
- An edge with `baud_en_i` low clears `cnt`, `acc`, `carry` and `osr_cnt`.
- `osr_tick_o` and `baud_tick_o` are 0 in the following cycle, so no tick is emitted and any in-flight tick is suppressed.
- The divisor registers keep their values.

## Timing
- Reset values:
  - `osr_tick_o` = 0, `baud_tick_o` = 0, `div_pending_o` = 0, `div_clamp_o` = 0.
  - `cnt`, `acc`, `carry`, `osr_cnt` = 0.
  - Active = shadow = {DEF_DIV, DEF_FRAC}.
- First tick: after `baud_en_i` rises, `osr_tick_o` is high in the cycle following the D-th edge at which `baud_en_i` is sampled high.
- Steady state: `osr_tick_o` is high for exactly 1 cycle per period P. The tick outputs have one cycle of register latency after the wrap edge.
- `div_pending_o`: updates the cycle after the strobe.
- `div_clamp_o`: updates the cycle after the transfer.
- Reset mid-period: all state returns to reset values immediately. No tick is emitted after reset asserts.
- Divisor of 0 or 1: clamped to 2. `osr_tick_o` never stays high for consecutive cycles.

## Configuration
- `UART_BAUD_FRAC_EN` defined: the fractional accumulator is present and behaves as described above.
- `UART_BAUD_FRAC_EN` undefined:
  - `acc` and `carry` are not implemented; `carry` reads as constant 0, so `P = D`.
  - `div_frac_i` is ignored.
  - The active and shadow frac fields are not implemented.
  - `DEF_FRAC` is unused.

## Test plan
- **Reset defaults.** Hold reset low, release with `baud_en_i`=1 → first `osr_tick_o` after 27 edges. With FRAC_EN, 16 consecutive periods total 16*27+2 = 434 cycles.
- **Integer period.** Write div 4 / frac 0 while disabled, then enable → `osr_tick_o` every 4 cycles; `baud_tick_o` on every 16th tick, every 64 cycles.
- **Half fraction.** Write div 4 / frac 8 (FRAC_EN) → periods 4,4,5,4,5,… and every 16 periods sum to 72 cycles. Without FRAC_EN → every period is 4.
- **Shadowed update.** With div 10 running, write div 6 mid-period → `div_pending_o`=1. The current period completes at 10 cycles, then periods become 6 and pending clears. A write coincident with the wrap edge applies directly with pending staying 0.
- **Clamp.** Write div 0 → `div_clamp_o`=1 after transfer; ticks every 2 cycles and never adjacent.
- **Disable and reset mid-period.** Drop `baud_en_i` at `cnt`=5 of 10 → no tick. Re-enable → first tick after a full 10 edges. Repeat with `reset_i` pulsed low mid-period → outputs go to 0 immediately and divisor returns to 27/2.
